if_id_buffer: RTL
=================

# if_id_buffer

Two-entry instruction buffer between the fetch stage (PC plus instruction memory) and decode. Captures each fetched {pc, instr} pair, presents it to decode with a valid/ready handshake, and back-pressures fetch when decode stalls. A taken branch discards everything in flight. It replaces a bare IF/ID register, so fetch can run one instruction ahead of a stalled decode without losing a word.

## Interface
- `N` (define.v), 31: MSB index of PC and instruction words (width `N`+1 = 32).
- `NOP` (define.v), 32'h0000_0000: instruction value driven on `id_instr` when empty or flushed.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `if_valid` in 1: fetch presents a valid instruction this cycle.
- `if_pc` in `N`+1: PC of the presented instruction.
- `if_instr` in `N`+1: instruction word from instruction memory.
- `if_ready` out 1: buffer accepts a push this cycle. Fetch holds its PC while this is low.
- `flush` in 1: branch taken; discard all buffered and incoming instructions.
- `id_valid` out 1: head entry is valid for decode.
- `id_pc` out `N`+1: PC of the head entry.
- `id_pc4` out `N`+1: `id_pc` + 4, modulo 2^32.
- `id_instr` out `N`+1: instruction of the head entry; `NOP` when `id_valid` = 0.
- `id_ready` in 1: decode consumes the head entry this cycle.

## Operation
- State machine `EMPTY` / `ONE` / `TWO` counts the valid entries. Storage is a head slot and a tail slot.
- Push = `if_valid` & `if_ready`. Pop = `id_valid` & `id_ready`.
- Transitions when `flush` = 0:
  - `EMPTY`: on push, go to `ONE` and load head.
  - `ONE`:
    - push only: go to `TWO` and load tail.
    - pop only: go to `EMPTY`.
    - push and pop together: stay in `ONE` and load head with the incoming pair.
  - `TWO`: on pop, go to `ONE` and move tail into head. No push is possible in this state.
- `flush` = 1 overrides all other inputs:
  - Next state is `EMPTY`; both slots are invalidated.
  - A push in the same cycle is dropped.
  - A pop in the same cycle is still counted by decode; the buffer does not care.
- `if_ready` = (state != `TWO`). It is decoded from registered state only, so there is no combinational path from `id_ready` to `if_ready`.
- `id_valid` = (state != `EMPTY`). `id_pc` and `id_instr` come straight from the head slot. `id_instr` is muxed to `NOP` when `id_valid` = 0.
- `id_pc4` is combinational from `id_pc`; carry out of bit `N` is discarded, so 32'hFFFF_FFFC + 4 = 0.
- Outputs hold stable while `id_valid` = 1 and `id_ready` = 0.

## Timing
- Reset (`rst` low, asynchronous), takes effect immediately and holds until release:
  - state `EMPTY`, head and tail PC = 0, head and tail instr = `NOP`.
  - `id_valid` = 0, `id_pc` = 0, `id_pc4` = 4, `id_instr` = `NOP`, `if_ready` = 1.
- Reset mid-operation drops all entries immediately, without waiting for a clock edge.
- Latency: a push at edge k makes `id_valid` = 1 with that pair after edge k. Pass-through latency is 1 cycle.
- Throughput is 1 instruction per cycle when `id_ready` is held high.
- `TWO` with pop: `if_ready` stays 0 for that cycle, and fetch resumes the cycle after.
- Flush at edge k: `id_valid` = 0 and `if_ready` = 1 after edge k. The next push is accepted at edge k+1 at the earliest.

## Structure
- `define.v` (shared include) holds `N` and `NOP`. State encodings are local parameters.
- One sub-module, `if_id_slot`: a resettable {valid-free pc, instr} register with load enable, instantiated twice (head and tail).
- The top level contains the FSM, the next-slot muxing and the output logic.

## Test plan
- Reset, streaming: release reset, push PCs 0x0, 0x4, 0x8 with instrs 0x2001_0005.. and `id_ready` = 1.
  - `id_pc` = 0x0, 0x4, 0x8 on consecutive cycles, each 1 cycle after its push.
  - `if_ready` stays 1 and `id_pc4` = `id_pc` + 4.
- Back-pressure: hold `id_ready` = 0 and push 0x10, 0x14, then offer 0x18.
  - State reaches `TWO` and `if_ready` = 0; 0x18 is not accepted.
  - `id_pc` holds at 0x10.
  - Raise `id_ready`: decode sees 0x10, 0x14, 0x18 in order with no loss or duplicate.
- Flush in `TWO`, with a push offered in the same cycle.
  - Next cycle: `id_valid` = 0, `id_instr` = `NOP`, `if_ready` = 1.
  - The pushed pair never appears at decode.
- Simultaneous push and pop in `ONE`: head 0x20, push 0x24 with `id_ready` = 1.
  - Next cycle: state `ONE` and `id_pc` = 0x24.
- Asynchronous reset mid-stream: assert `rst` low between edges while in `TWO`.
  - Outputs go to their reset values immediately.
  - After release, the first push appears with the correct PC.
- Wrap-around: push PC 32'hFFFF_FFFC.
  - `id_pc4` = 32'h0000_0000.

Source files
------------

// File: rtl/if_id_buffer_pkg.sv
// Shared widths, reset values, state encoding and entry type for the IF/ID instruction buffer.
package if_id_buffer_pkg;

  localparam int N = 31;
  localparam int W = N + 1;
  localparam logic [N:0] NOP = 32'h0000_0000;
  localparam logic [N:0] PC_RESET = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [N:0] pc;
    logic [N:0] instr;
  } entry_t;

  // Sequential PC of the next word; the carry out of bit N is dropped.
  function automatic logic [N:0] pc_plus4(input logic [N:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_slot.sv
// One storage slot of the buffer: a {pc, instr} register with load enable and no valid bit.
module if_id_slot
  import if_id_buffer_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  entry_t d,
  output entry_t q
);

  entry_t slot_r;

  // Slot storage: cleared to PC 0 / NOP on reset, written only when load is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_r <= {PC_RESET, NOP};
    end else if (load) begin
      slot_r <= d;
    end else begin
      slot_r <= slot_r;
    end
  end

  assign q = slot_r;

endmodule

// File: rtl/if_id_buffer.sv
// Two-entry IF/ID instruction buffer: valid/ready handshake to decode, back-pressure to fetch,
// and a flush that discards everything in flight on a taken branch.
module if_id_buffer
  import if_id_buffer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       if_valid,
  input  logic [N:0] if_pc,
  input  logic [N:0] if_instr,
  output logic       if_ready,
  input  logic       flush,
  output logic       id_valid,
  output logic [N:0] id_pc,
  output logic [N:0] id_pc4,
  output logic [N:0] id_instr,
  input  logic       id_ready
);

  state_e state_r;
  state_e state_next_s;
  entry_t in_entry_s;
  entry_t head_d_s;
  entry_t head_q_s;
  entry_t tail_q_s;
  logic   head_load_s;
  logic   tail_load_s;
  logic   push_s;
  logic   pop_s;

  assign in_entry_s = {if_pc, if_instr};

  // Both handshake outputs decode registered state only, so id_ready never reaches if_ready.
  assign if_ready = (state_r != TWO);
  assign id_valid = (state_r != EMPTY);
  assign push_s   = if_valid & if_ready;
  assign pop_s    = id_valid & id_ready;

  // Occupancy register; reset drops every entry without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next occupancy and slot load selection; flush wins over any push or pop.
  always_comb begin
    state_next_s = state_r;
    head_load_s  = 1'b0;
    tail_load_s  = 1'b0;
    head_d_s     = in_entry_s;
    if (flush) begin
      state_next_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (push_s) begin
            state_next_s = ONE;
            head_load_s  = 1'b1;
          end else begin
            state_next_s = EMPTY;
          end
        end
        ONE: begin
          if (push_s && pop_s) begin
            state_next_s = ONE;
            head_load_s  = 1'b1;
          end else if (push_s) begin
            state_next_s = TWO;
            tail_load_s  = 1'b1;
          end else if (pop_s) begin
            state_next_s = EMPTY;
          end else begin
            state_next_s = ONE;
          end
        end
        TWO: begin
          // Fetch is stalled here, so the only movement is tail advancing into head.
          if (pop_s) begin
            state_next_s = ONE;
            head_load_s  = 1'b1;
            head_d_s     = tail_q_s;
          end else begin
            state_next_s = TWO;
          end
        end
        default: begin
          state_next_s = EMPTY;
        end
      endcase
    end
  end

  if_id_slot u_head (
    .clk  (clk),
    .rst  (rst),
    .load (head_load_s),
    .d    (head_d_s),
    .q    (head_q_s)
  );

  if_id_slot u_tail (
    .clk  (clk),
    .rst  (rst),
    .load (tail_load_s),
    .d    (in_entry_s),
    .q    (tail_q_s)
  );

  assign id_pc    = head_q_s.pc;
  assign id_pc4   = pc_plus4(head_q_s.pc);
  assign id_instr = id_valid ? head_q_s.instr : NOP;

endmodule
